mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle control FSM that sequences the shared 32-bit ALU, register file and unified instruction/data memory for the MIPS-subset core.
- Decodes opcode/funct into per-state strobes and drives the ALU's 4-bit ALUcontrol.
- Stalls on a memory ready handshake.
- Counts retired instructions and illegal instructions for debug.

Parameters:
- CNT_W, 32, width of retired/illegal counters (wrap-around).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instr[31:26], valid from DECODE onward (IR held).
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag, combinational from current operands.
- mem_ready  in  1  memory completes access this cycle.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut.
- ir_write  out  1  latch instruction register.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = MDR to register file.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- pc_src  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- pc_en  out  1  PC load = pc_write | (branch & zero).
- alu_control  out  4  0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 slt.
- illegal  out  1  one-cycle pulse on undecodable instruction.
- retired  out  CNT_W  instructions completed.
- state_dbg  out  4  current state encoding.

Behaviour:
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
  - Codes 12–15 unreachable; if entered, go to FETCH next cycle.
- Outputs are Moore, decoded from the registered state; exceptions are pc_en (uses zero) and the mem_ready-qualified strobes below.
- Reset:
  - rst=1 at an edge sets state=FETCH and clears retired and the illegal register.
  - While rst=1, all strobes are forced 0, alu_control=0010 and state_dbg=0.
  - Reset mid-instruction aborts it; no partial write may occur in the rst cycle.
- FETCH:
  - Asserts mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu add, pc_src=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1.
  - Holds state while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, add (branch target precompute).
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - Any other opcode -> FETCH with illegal=1 for one cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, add; go to MEMRD if lw, MEMWR if sw.
- MEMRD: mem_read=1, i_or_d=1; hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
- MEMWR:
  - mem_write=1, i_or_d=1; hold until mem_ready, then FETCH.
  - mem_write stays asserted through the stall; memory takes the write exactly once, on the mem_ready cycle.
- EXEC:
  - alu_src_a=1, alu_src_b=00.
  - alu_control from funct: 100000 add=0010, 100010 sub=0110, 100100 and=0000, 100101 or=0001, 101010 slt=0111.
  - Known funct -> ALUWB. Unknown funct -> FETCH with illegal pulse and no register write.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, branch=1, pc_src=01; pc_en=zero; then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add; then ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
- JUMP: pc_write=1, pc_src=10; then FETCH.
- States not listed above drive all strobes at 0 and alu_control=0010.
- retired:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, ADDIWB or JUMP.
  - Does not increment on an illegal-instruction exit.
  - Wraps from 2^CNT_W−1 to 0.
- Latencies from FETCH entry, zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
- pc_en and reg_write are never asserted together with mem_write.

Decomposition:
- Package mc_pkg holds:
  - state enum/encodings
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALU code constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT
- One sub-module, alu_decode: purely combinational (state-class, funct) -> alu_control plus a funct_valid flag.
- FSM, counters and output decode stay in mc_control.

Test Plan:
- Reset: assert rst 3 cycles during MEMWR with mem_ready=1 -> mem_write=0 throughout, state_dbg=0, retired=0 after release.
- lw with mem_ready=1 always -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in cycle 5; retired 0->1.
- R-type sub (funct 100010) -> alu_control=0110 in EXEC, reg_dst=1 in ALUWB; funct 111111 -> illegal pulse, no reg_write, retired unchanged.
- beq with zero=1 -> pc_en=1, pc_src=01 in BRANCH; repeat with zero=0 -> pc_en=0; both retire.
- sw with mem_ready low for 3 cycles in MEMWR -> state held at 5, mem_write high 4 cycles, exactly one retire.
- opcode 111111 -> DECODE goes to FETCH, illegal high exactly 1 cycle; preload retired=2^32−1, run j -> retired wraps to 0.

Source files
------------

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_pkg
//  Purpose  : Shared state encodings, opcode/funct constants and ALU codes
//             for the multi-cycle MIPS-subset control unit.
//  Revision : 1.0  initial release
// ============================================================================
package mc_pkg;

   // Controller states; codes 12-15 are unused and recover to FETCH
   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_ALUWB  = 4'd7,
      ST_BRANCH = 4'd8,
      ST_ADDIEX = 4'd9,
      ST_ADDIWB = 4'd10,
      ST_JUMP   = 4'd11
   } state_t;

   // Opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type funct codes (instr[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU operation codes
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   // What kind of ALU operation the current state needs
   localparam logic [1:0] ACLS_ADD   = 2'd0;
   localparam logic [1:0] ACLS_SUB   = 2'd1;
   localparam logic [1:0] ACLS_FUNCT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mc_control_alu_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decode
//  Purpose  : Combinational ALU control: maps the state's operation class
//             and the R-type funct field to the 4-bit ALU code.
//  Revision : 1.0  initial release
// ============================================================================
module alu_decode
   import mc_pkg::*;
(
   input  logic [1:0] alu_class,
   input  logic [5:0] funct,
   output logic [3:0] alu_control,
   output logic       funct_valid
);

   logic [3:0] funct_alu;

   // Translate funct to an ALU code and flag unsupported encodings
   always_comb begin
      funct_valid = 1'b1;
      funct_alu   = ALU_ADD;
      case (funct)
         FN_ADD:  funct_alu = ALU_ADD;
         FN_SUB:  funct_alu = ALU_SUB;
         FN_AND:  funct_alu = ALU_AND;
         FN_OR:   funct_alu = ALU_OR;
         FN_SLT:  funct_alu = ALU_SLT;
         default: funct_valid = 1'b0;
      endcase
   end

   // Select fixed add/sub or the funct-derived code by operation class
   always_comb begin
      case (alu_class)
         ACLS_SUB:   alu_control = ALU_SUB;
         ACLS_FUNCT: alu_control = funct_alu;
         default:    alu_control = ALU_ADD;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control
//  Purpose  : Multi-cycle control FSM for the MIPS-subset core. Sequences
//             the shared ALU, register file and unified memory, stalls on
//             mem_ready and keeps retired-instruction / illegal debug state.
//  Revision : 1.0  initial release
// ============================================================================
module mc_control
   import mc_pkg::*;
#(
   parameter int CNT_W = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic             i_or_d,
   output logic             ir_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       pc_src,
   output logic             pc_en,
   output logic [3:0]       alu_control,
   output logic             illegal,
   output logic [CNT_W-1:0] retired,
   output logic [3:0]       state_dbg
);

   state_t     state;
   logic       illegal_q;
   logic       pc_write;
   logic       branch;
   logic [1:0] alu_class;
   logic       funct_valid;

   alu_decode u_alu_decode (
      .alu_class   (alu_class),
      .funct       (funct),
      .alu_control (alu_control),
      .funct_valid (funct_valid)
   );

   // State transitions, retire counting and the illegal-instruction pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_FETCH;
         retired   <= '0;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= 1'b0;
         case (state)
            ST_FETCH:  if (mem_ready) state <= ST_DECODE;
            ST_DECODE: begin
               case (opcode)
                  OP_LW, OP_SW: state <= ST_MEMADR;
                  OP_RTYPE:     state <= ST_EXEC;
                  OP_BEQ:       state <= ST_BRANCH;
                  OP_ADDI:      state <= ST_ADDIEX;
                  OP_J:         state <= ST_JUMP;
                  default: begin
                     state     <= ST_FETCH;
                     illegal_q <= 1'b1;
                  end
               endcase
            end
            // Only lw and sw reach MEMADR, so anything not lw is a store
            ST_MEMADR: state <= (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (mem_ready) state <= ST_MEMWB;
            ST_MEMWR: begin
               if (mem_ready) begin
                  state   <= ST_FETCH;
                  retired <= retired + CNT_W'(1);
               end
            end
            ST_EXEC: begin
               if (funct_valid) begin
                  state <= ST_ALUWB;
               end else begin
                  state     <= ST_FETCH;
                  illegal_q <= 1'b1;
               end
            end
            ST_ADDIEX: state <= ST_ADDIWB;
            ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_ADDIWB, ST_JUMP: begin
               state   <= ST_FETCH;
               retired <= retired + CNT_W'(1);
            end
            default:   state <= ST_FETCH;
         endcase
      end
   end

   // Moore output decode; reset masks every strobe so an aborted
   // instruction can never write in the reset cycle
   always_comb begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      pc_write   = 1'b0;
      branch     = 1'b0;
      alu_class  = ACLS_ADD;
      if (!rst) begin
         case (state)
            ST_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            ST_DECODE: alu_src_b = 2'b11;
            ST_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            ST_MEMRD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            ST_EXEC: begin
               alu_src_a = 1'b1;
               alu_class = ACLS_FUNCT;
            end
            ST_ALUWB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
               alu_src_a = 1'b1;
               alu_class = ACLS_SUB;
               branch    = 1'b1;
               pc_src    = 2'b01;
            end
            ST_ADDIEX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            ST_ADDIWB: reg_write = 1'b1;
            ST_JUMP: begin
               pc_write = 1'b1;
               pc_src   = 2'b10;
            end
            default: ;
         endcase
      end
   end

   // PC load, illegal pulse and debug state view
   always_comb begin
      pc_en     = pc_write | (branch & zero);
      illegal   = illegal_q & ~rst;
      state_dbg = rst ? 4'd0 : state;
   end

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_control
//  Purpose  : Table-driven cycle-by-cycle check of mc_control, plus a
//             retired-counter wrap sequence on a narrow-counter instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_control;

   // Strobe pack: mem_read,mem_write,i_or_d,ir_write,reg_dst,mem_to_reg,
   //              reg_write,alu_src_a,alu_src_b[2],pc_src[2],pc_en,illegal
   localparam logic [13:0] P_RST  = 14'b00000000_00_00_0_0;
   localparam logic [13:0] P_FR   = 14'b10010000_01_00_1_0;
   localparam logic [13:0] P_FW   = 14'b10000000_01_00_0_0;
   localparam logic [13:0] P_FRI  = 14'b10010000_01_00_1_1;
   localparam logic [13:0] P_FWI  = 14'b10000000_01_00_0_1;
   localparam logic [13:0] P_DEC  = 14'b00000000_11_00_0_0;
   localparam logic [13:0] P_MADR = 14'b00000001_10_00_0_0;
   localparam logic [13:0] P_MRD  = 14'b10100000_00_00_0_0;
   localparam logic [13:0] P_MWB  = 14'b00000110_00_00_0_0;
   localparam logic [13:0] P_MWR  = 14'b01100000_00_00_0_0;
   localparam logic [13:0] P_EXE  = 14'b00000001_00_00_0_0;
   localparam logic [13:0] P_AWB  = 14'b00001010_00_00_0_0;
   localparam logic [13:0] P_BR1  = 14'b00000001_00_01_1_0;
   localparam logic [13:0] P_BR0  = 14'b00000001_00_01_0_0;
   localparam logic [13:0] P_AIEX = 14'b00000001_10_00_0_0;
   localparam logic [13:0] P_AIWB = 14'b00000010_00_00_0_0;
   localparam logic [13:0] P_JMP  = 14'b00000000_00_10_1_0;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
   localparam logic [5:0] BAD = 6'b111111, FSUB = 6'b100010;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        zero;
      logic        rdy;
      logic [3:0]  st;
      logic [13:0] str;
      logic [3:0]  alu;
      logic        chk_alu;
      logic [31:0] ret;
   } vec_t;

   vec_t vecs[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, zero, mem_ready;
   logic [5:0]  opcode, funct;
   logic        mem_read, mem_write, i_or_d, ir_write, reg_dst, mem_to_reg;
   logic        reg_write, alu_src_a, pc_en, illegal;
   logic [1:0]  alu_src_b, pc_src;
   logic [3:0]  alu_control, state_dbg;
   logic [31:0] retired;

   logic        n_mem_read, n_mem_write, n_i_or_d, n_ir_write, n_reg_dst;
   logic        n_mem_to_reg, n_reg_write, n_alu_src_a, n_pc_en, n_illegal;
   logic [1:0]  n_alu_src_b, n_pc_src;
   logic [3:0]  n_alu_control, n_state_dbg;
   logic [1:0]  n_retired;

   int n_checks = 0;
   int n_fail   = 0;

   mc_control #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
      .i_or_d(i_or_d), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en),
      .alu_control(alu_control), .illegal(illegal), .retired(retired),
      .state_dbg(state_dbg)
   );

   // Narrow counter instance shares all stimulus to exercise wrap-around
   mc_control #(.CNT_W(2)) dut_narrow (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_read(n_mem_read), .mem_write(n_mem_write),
      .i_or_d(n_i_or_d), .ir_write(n_ir_write), .reg_dst(n_reg_dst),
      .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write),
      .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .pc_src(n_pc_src),
      .pc_en(n_pc_en), .alu_control(n_alu_control), .illegal(n_illegal),
      .retired(n_retired), .state_dbg(n_state_dbg)
   );

   wire [13:0] act_str = {mem_read, mem_write, i_or_d, ir_write, reg_dst,
                          mem_to_reg, reg_write, alu_src_a, alu_src_b,
                          pc_src, pc_en, illegal};

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy, input logic [3:0] st,
                      input logic [13:0] str, input logic [3:0] alu,
                      input logic ca, input logic [31:0] ret);
      vec_t v;
      v.rst = r; v.op = op; v.fn = fn; v.zero = z; v.rdy = rdy;
      v.st = st; v.str = str; v.alu = alu; v.chk_alu = ca; v.ret = ret;
      vecs.push_back(v);
   endtask

   initial begin
      rst = 1'b1; opcode = LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

      // Reset
      add(1, LW, 0, 0, 1, 0, P_RST, 4'h2, 1, 0);
      add(1, LW, 0, 0, 1, 0, P_RST, 4'h2, 1, 0);
      // lw, zero-wait: 0,1,2,3,4 then retire
      add(0, LW, 0, 0, 1, 0, P_FR,   4'h2, 1, 0);
      add(0, LW, 0, 0, 1, 1, P_DEC,  4'h2, 1, 0);
      add(0, LW, 0, 0, 1, 2, P_MADR, 4'h2, 1, 0);
      add(0, LW, 0, 0, 1, 3, P_MRD,  4'h2, 1, 0);
      add(0, LW, 0, 0, 1, 4, P_MWB,  4'h2, 1, 0);
      // R-type sub
      add(0, RT, FSUB, 0, 1, 0, P_FR,  4'h2, 1, 1);
      add(0, RT, FSUB, 0, 1, 1, P_DEC, 4'h2, 1, 1);
      add(0, RT, FSUB, 0, 1, 6, P_EXE, 4'h6, 1, 1);
      add(0, RT, FSUB, 0, 1, 7, P_AWB, 4'h2, 1, 1);
      // R-type with unknown funct: illegal pulse, no write, no retire
      add(0, RT, BAD, 0, 1, 0, P_FR,  4'h2, 1, 2);
      add(0, RT, BAD, 0, 1, 1, P_DEC, 4'h2, 1, 2);
      add(0, RT, BAD, 0, 1, 6, P_EXE, 4'h2, 0, 2);
      // beq taken (FETCH row carries the illegal pulse from above)
      add(0, BEQ, 0, 1, 1, 0, P_FRI, 4'h2, 1, 2);
      add(0, BEQ, 0, 1, 1, 1, P_DEC, 4'h2, 1, 2);
      add(0, BEQ, 0, 1, 1, 8, P_BR1, 4'h6, 1, 2);
      // beq not taken
      add(0, BEQ, 0, 0, 1, 0, P_FR,  4'h2, 1, 3);
      add(0, BEQ, 0, 0, 1, 1, P_DEC, 4'h2, 1, 3);
      add(0, BEQ, 0, 0, 1, 8, P_BR0, 4'h6, 1, 3);
      // sw with three stall cycles in MEMWR
      add(0, SW, 0, 0, 1, 0, P_FR,   4'h2, 1, 4);
      add(0, SW, 0, 0, 1, 1, P_DEC,  4'h2, 1, 4);
      add(0, SW, 0, 0, 1, 2, P_MADR, 4'h2, 1, 4);
      add(0, SW, 0, 0, 0, 5, P_MWR,  4'h2, 1, 4);
      add(0, SW, 0, 0, 0, 5, P_MWR,  4'h2, 1, 4);
      add(0, SW, 0, 0, 0, 5, P_MWR,  4'h2, 1, 4);
      add(0, SW, 0, 0, 1, 5, P_MWR,  4'h2, 1, 4);
      // Illegal opcode: back to FETCH, illegal high for exactly one cycle
      add(0, BAD, 0, 0, 1, 0, P_FR,  4'h2, 1, 5);
      add(0, BAD, 0, 0, 1, 1, P_DEC, 4'h2, 1, 5);
      add(0, BAD, 0, 0, 0, 0, P_FWI, 4'h2, 1, 5);
      add(0, BAD, 0, 0, 0, 0, P_FW,  4'h2, 1, 5);
      // addi
      add(0, ADDI, 0, 0, 1, 0,  P_FR,   4'h2, 1, 5);
      add(0, ADDI, 0, 0, 1, 1,  P_DEC,  4'h2, 1, 5);
      add(0, ADDI, 0, 0, 1, 9,  P_AIEX, 4'h2, 1, 5);
      add(0, ADDI, 0, 0, 1, 10, P_AIWB, 4'h2, 1, 5);
      // j
      add(0, JMP, 0, 0, 1, 0,  P_FR,  4'h2, 1, 6);
      add(0, JMP, 0, 0, 1, 1,  P_DEC, 4'h2, 1, 6);
      add(0, JMP, 0, 0, 1, 11, P_JMP, 4'h2, 1, 6);
      // sw aborted by a 3-cycle reset while in MEMWR with mem_ready=1
      add(0, SW, 0, 0, 1, 0, P_FR,   4'h2, 1, 7);
      add(0, SW, 0, 0, 1, 1, P_DEC,  4'h2, 1, 7);
      add(0, SW, 0, 0, 1, 2, P_MADR, 4'h2, 1, 7);
      add(1, SW, 0, 0, 1, 0, P_RST,  4'h2, 1, 7);
      add(1, SW, 0, 0, 1, 0, P_RST,  4'h2, 1, 0);
      add(1, SW, 0, 0, 1, 0, P_RST,  4'h2, 1, 0);
      add(0, SW, 0, 0, 0, 0, P_FW,   4'h2, 1, 0);

      @(posedge clk); #1;
      foreach (vecs[i]) begin
         rst = vecs[i].rst; opcode = vecs[i].op; funct = vecs[i].fn;
         zero = vecs[i].zero; mem_ready = vecs[i].rdy;
         @(negedge clk);
         chk($sformatf("state row %0d", i), 32'(state_dbg), 32'(vecs[i].st));
         chk($sformatf("strobes row %0d", i), 32'(act_str), 32'(vecs[i].str));
         if (vecs[i].chk_alu)
            chk($sformatf("alu row %0d", i), 32'(alu_control), 32'(vecs[i].alu));
         chk($sformatf("retired row %0d", i), retired, vecs[i].ret);
         chk($sformatf("retired_narrow row %0d", i), 32'(n_retired),
             32'(vecs[i].ret[1:0]));
         chk($sformatf("exclusive row %0d", i),
             32'(mem_write & (pc_en | reg_write)), 32'd0);
         @(posedge clk); #1;
      end

      // Four jumps from a cleared counter: narrow counter runs 1,2,3,0
      for (int k = 1; k <= 4; k++) begin
         opcode = JMP; mem_ready = 1'b1; zero = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         @(negedge clk);
         chk($sformatf("j%0d state", k), 32'(state_dbg), 32'd0);
         chk($sformatf("j%0d retired", k), retired, 32'(k));
         chk($sformatf("j%0d retired_wrap", k), 32'(n_retired), 32'(k % 4));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
